// File: rtl/change_return_checker_pkg.sv
// rtl/change_return_checker_pkg.sv - shared constants and state encoding for the change-return checker
package change_pkg;

   localparam int AMT_W       = 5;
   localparam int CNT_W       = 4;
   localparam int VAL_BIG     = 10;
   localparam int VAL_SMALL   = 2;
   localparam int TIMEOUT_CYC = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } state_t;

endpackage

// File: rtl/change_return_checker_if.sv
// rtl/change_return_checker_if.sv - controller-side stimulus and checker result bundle
interface change_return_checker_if #(
   parameter int AMT_W = 5,
   parameter int CNT_W = 4
);
   logic             start;
   logic [AMT_W-1:0] inserted;
   logic [AMT_W-1:0] price;
   logic             DEZ;
   logic             DOIS;
   logic             FIM;
   logic [AMT_W-1:0] received;
   logic [CNT_W-1:0] dezCount;
   logic [CNT_W-1:0] doisCount;
   logic             done;
   logic             ok;
   logic             mismatch;
   logic             overflow;
   logic [1:0]       checkerState;

   modport master (
      output start, inserted, price, DEZ, DOIS, FIM,
      input  received, dezCount, doisCount, done, ok, mismatch, overflow, checkerState
   );

   modport slave (
      input  start, inserted, price, DEZ, DOIS, FIM,
      output received, dezCount, doisCount, done, ok, mismatch, overflow, checkerState
   );
endinterface

// File: rtl/change_return_checker_pulse_edge_detect.sv
// rtl/change_return_checker_pulse_edge_detect.sv - rising-edge detector for the DEZ/DOIS/FIM levels
module pulse_edge_detect (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] din,
   output logic [2:0] rise
);
   logic [2:0] prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) prev <= '0;
      else       prev <= din;
   end

   assign rise = din & ~prev;
endmodule

// File: rtl/change_return_checker.sv
// rtl/change_return_checker.sv - audits returned change against inserted minus price
// Optional watchdog on a stalled dispense enabled by CHANGE_TIMEOUT_EN.
module change_return_checker
   import change_pkg::*;
#(
   parameter int AMT_W       = change_pkg::AMT_W,
   parameter int CNT_W       = change_pkg::CNT_W,
   parameter int VAL_BIG     = change_pkg::VAL_BIG,
   parameter int VAL_SMALL   = change_pkg::VAL_SMALL
`ifdef CHANGE_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = change_pkg::TIMEOUT_CYC
`endif
) (
   input logic                   clock,
   input logic                   reset,
   change_return_checker_if.slave bus
);
   localparam int AMT_MAX = (1 << AMT_W) - 1;

   state_t           state, nxt_state;
   logic [AMT_W-1:0] expected, nxt_expected;
   logic [AMT_W-1:0] received, nxt_received;
   logic [CNT_W-1:0] dez_cnt, nxt_dez_cnt;
   logic [CNT_W-1:0] dois_cnt, nxt_dois_cnt;
   logic             done_r, nxt_done;
   logic             ok_r, nxt_ok;
   logic             mis_r, nxt_mis;
   logic             ovf_r, nxt_ovf;
   logic [2:0]       rise;
   logic             dez_rise, dois_rise, fim_rise;
   int               sum;

`ifdef CHANGE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0] tmr, nxt_tmr;
`endif

   pulse_edge_detect u_edge (
      .clock (clock),
      .reset (reset),
      .din   ({bus.FIM, bus.DOIS, bus.DEZ}),
      .rise  (rise)
   );

   assign dez_rise  = rise[0];
   assign dois_rise = rise[1];
   assign fim_rise  = rise[2];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         expected <= '0;
         received <= '0;
         dez_cnt  <= '0;
         dois_cnt <= '0;
         done_r   <= 1'b0;
         ok_r     <= 1'b0;
         mis_r    <= 1'b0;
         ovf_r    <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
         tmr      <= '0;
`endif
      end else begin
         state    <= nxt_state;
         expected <= nxt_expected;
         received <= nxt_received;
         dez_cnt  <= nxt_dez_cnt;
         dois_cnt <= nxt_dois_cnt;
         done_r   <= nxt_done;
         ok_r     <= nxt_ok;
         mis_r    <= nxt_mis;
         ovf_r    <= nxt_ovf;
`ifdef CHANGE_TIMEOUT_EN
         tmr      <= nxt_tmr;
`endif
      end
   end

   always_comb begin
      nxt_state    = state;
      nxt_expected = expected;
      nxt_received = received;
      nxt_dez_cnt  = dez_cnt;
      nxt_dois_cnt = dois_cnt;
      nxt_done     = done_r;
      nxt_ok       = ok_r;
      nxt_mis      = mis_r;
      nxt_ovf      = ovf_r;
      sum          = 0;
`ifdef CHANGE_TIMEOUT_EN
      nxt_tmr      = tmr;
`endif
      // start overrides whatever the current state is doing, including a FIM edge
      if (bus.start) begin
         nxt_expected = bus.inserted - bus.price;
         nxt_received = '0;
         nxt_dez_cnt  = '0;
         nxt_dois_cnt = '0;
         nxt_ovf      = 1'b0;
         nxt_ok       = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
         nxt_tmr      = '0;
`endif
         if (bus.price > bus.inserted) begin
            nxt_state = DONE;
            nxt_done  = 1'b1;
            nxt_mis   = 1'b1;
         end else begin
            nxt_state = COLLECT;
            nxt_done  = 1'b0;
            nxt_mis   = 1'b0;
         end
      end else if (state == COLLECT) begin
         sum = int'(received) + (dez_rise ? VAL_BIG : 0) + (dois_rise ? VAL_SMALL : 0);
         if (sum > AMT_MAX) begin
            nxt_received = '1;
            nxt_ovf      = 1'b1;
         end else begin
            nxt_received = AMT_W'(sum);
         end
         if (dez_rise) begin
            if (dez_cnt == '1) nxt_ovf = 1'b1;
            else               nxt_dez_cnt = dez_cnt + 1'b1;
         end
         if (dois_rise) begin
            if (dois_cnt == '1) nxt_ovf = 1'b1;
            else                nxt_dois_cnt = dois_cnt + 1'b1;
         end
         // coins arriving with FIM are already folded into nxt_received
         if (fim_rise) begin
            nxt_state = DONE;
            nxt_done  = 1'b1;
            nxt_ok    = (nxt_received == expected) && !nxt_ovf;
            nxt_mis   = !((nxt_received == expected) && !nxt_ovf);
         end
`ifdef CHANGE_TIMEOUT_EN
         else if (dez_rise || dois_rise) begin
            nxt_tmr = '0;
         end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
            nxt_state = TIMEOUT;
            nxt_done  = 1'b1;
            nxt_ok    = 1'b0;
            nxt_mis   = 1'b1;
         end else begin
            nxt_tmr = tmr + 1'b1;
         end
`endif
      end
   end

   assign bus.received     = received;
   assign bus.dezCount     = dez_cnt;
   assign bus.doisCount    = dois_cnt;
   assign bus.done         = done_r;
   assign bus.ok           = ok_r;
   assign bus.mismatch     = mis_r;
   assign bus.overflow     = ovf_r;
   assign bus.checkerState = state;
endmodule

// File: tb/tb_change_return_checker.sv
// tb/tb_change_return_checker.sv - directed scoreboard bench for change_return_checker
module tb_change_return_checker;

   typedef struct {
      logic [4:0] received;
      logic [3:0] dez;
      logic [3:0] dois;
      logic       ok;
      logic       mismatch;
      logic       overflow;
      logic [1:0] st;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   change_return_checker_if bus ();

   change_return_checker dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic step(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int r, input int d, input int s, input logic o,
                           input logic m, input logic v, input int st);
      exp_t e;
      e.received = r[4:0];
      e.dez      = d[3:0];
      e.dois     = s[3:0];
      e.ok       = o;
      e.mismatch = m;
      e.overflow = v;
      e.st       = st[1:0];
      sb.push_back(e);
   endtask

   task automatic do_start(input int ins, input int pr);
      bus.inserted = ins[4:0];
      bus.price    = pr[4:0];
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
   endtask

   task automatic pulse(input int which, input int width);
      case (which)
         0: bus.DEZ = 1'b1;
         1: bus.DOIS = 1'b1;
         2: bus.FIM = 1'b1;
         default: begin bus.DEZ = 1'b1; bus.DOIS = 1'b1; end
      endcase
      step(width);
      bus.DEZ = 1'b0; bus.DOIS = 1'b0; bus.FIM = 1'b0;
      step(2);
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed empty scoreboard expected one entry", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".received"}, bus.received, e.received);
      chk({tag, ".dezCount"}, bus.dezCount, e.dez);
      chk({tag, ".doisCount"}, bus.doisCount, e.dois);
      chk({tag, ".ok"}, bus.ok, e.ok);
      chk({tag, ".mismatch"}, bus.mismatch, e.mismatch);
      chk({tag, ".overflow"}, bus.overflow, e.overflow);
      chk({tag, ".state"}, bus.checkerState, e.st);
      chk({tag, ".done"}, bus.done, 1'b1);
   endtask

   // raise FIM, measure clocks until done, then compare against the scoreboard
   task automatic finish_txn(input string tag);
      int lat = 0;
      chk({tag, ".done_before_fim"}, bus.done, 1'b0);
      bus.FIM = 1'b1;
      do begin
         step();
         lat++;
      end while (!bus.done && lat < 10);
      chk({tag, ".latency"}, lat, 1);
      check_result(tag);
      bus.FIM = 1'b0;
      step(2);
   endtask

   initial begin
      bus.start = 1'b0; bus.inserted = '0; bus.price = '0;
      bus.DEZ = 1'b0; bus.DOIS = 1'b0; bus.FIM = 1'b0;
      step(2);
      chk("reset.state", bus.checkerState, 2'd0);
      chk("reset.outputs", {bus.received, bus.dezCount, bus.doisCount, bus.done,
                            bus.ok, bus.mismatch, bus.overflow}, '0);
      reset = 1'b0;
      step();

      pulse(0, 1);
      pulse(2, 1);
      chk("idle.ignore", {bus.checkerState, bus.received, bus.dezCount, bus.done}, '0);

      do_start(30, 28);
      push_exp(2, 0, 1, 1'b1, 1'b0, 1'b0, 2);
      chk("t1.collect", bus.checkerState, 2'd1);
      pulse(1, 3);
      finish_txn("t1");

      do_start(30, 14);
      push_exp(16, 1, 3, 1'b1, 1'b0, 1'b0, 2);
      pulse(0, 2);
      for (int i = 0; i < 3; i++) pulse(1, 1);
      finish_txn("t2");

      do_start(20, 2);
      push_exp(16, 1, 3, 1'b0, 1'b1, 1'b0, 2);
      pulse(0, 1);
      for (int i = 0; i < 3; i++) pulse(1, 2);
      finish_txn("t3");

      do_start(10, 12);
      push_exp(0, 0, 0, 1'b0, 1'b1, 1'b0, 2);
      check_result("t4");
      pulse(0, 1);
      pulse(1, 1);
      pulse(2, 1);
      chk("t4.hold", {bus.checkerState, bus.received, bus.dezCount, bus.doisCount,
                      bus.done, bus.ok, bus.mismatch}, {2'd2, 5'd0, 4'd0, 4'd0, 3'b101});

      do_start(30, 0);
      push_exp(31, 4, 0, 1'b0, 1'b1, 1'b1, 2);
      for (int i = 0; i < 3; i++) pulse(0, 1);
      chk("t5.pre_sat", {bus.received, bus.overflow}, {5'd30, 1'b0});
      pulse(0, 1);
      chk("t5.sat", {bus.received, bus.overflow}, {5'd31, 1'b1});
      finish_txn("t5");

      // restart mid-collect drops the first transaction; DEZ and DOIS together add 12
      do_start(30, 28);
      pulse(0, 1);
      chk("t6.first", bus.received, 5'd10);
      do_start(30, 14);
      push_exp(16, 1, 3, 1'b1, 1'b0, 1'b0, 2);
      chk("t6.restart", {bus.checkerState, bus.received, bus.dezCount, bus.done},
          {2'd1, 5'd0, 4'd0, 1'b0});
      pulse(3, 1);
      chk("t6.both", bus.received, 5'd12);
      pulse(1, 1);
      pulse(1, 1);
      finish_txn("t6");

      do_start(30, 20);
      pulse(0, 1);
      chk("t7.mid", {bus.checkerState, bus.received}, {2'd1, 5'd10});
      #2 reset = 1'b1;
      #1;
      chk("t7.async_reset", {bus.checkerState, bus.received, bus.dezCount, bus.doisCount,
                             bus.done, bus.ok, bus.mismatch, bus.overflow}, '0);
      step();
      reset = 1'b0;
      step();

      do_start(30, 20);
      pulse(0, 1);
`ifdef CHANGE_TIMEOUT_EN
      step(70);
      chk("t8.timeout", {bus.checkerState, bus.done, bus.ok, bus.mismatch},
          {2'd3, 1'b1, 1'b0, 1'b1});
`else
      step(80);
      chk("t8.no_timeout", {bus.checkerState, bus.done}, {2'd1, 1'b0});
      push_exp(10, 1, 0, 1'b1, 1'b0, 1'b0, 2);
      finish_txn("t8");
`endif

      chk("sb.drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
